// File: rtl/eviction_write_buffer_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ewb_types
// Description : Shared types and widths for the eviction write buffer.
// Revision    : 1.0
// ============================================================================
package ewb_types;

    localparam int LINE_WIDTH = 256;
    localparam int ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } ewb_state_t;

endpackage
`default_nettype wire

// File: rtl/eviction_write_buffer_control.sv
`default_nettype none
// ============================================================================
// Module      : eviction_write_buffer_control
// Description : Sequences a single-entry eviction write buffer between the
//               cache and physical memory (absorb, forward, drain, defer).
// Revision    : 1.0
// ============================================================================
module eviction_write_buffer_control
    import ewb_types::*;
#(
    parameter int MAX_DEFER   = 4,
    parameter int OFFSET_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cache_read,
    input  logic                  cache_write,
    input  logic [ADDR_WIDTH-1:0] cache_address,
    output logic [LINE_WIDTH-1:0] cache_rdata,
    output logic                  cache_resp,
    input  logic                  buf_valid,
    input  logic [ADDR_WIDTH-1:0] buf_address,
    input  logic [LINE_WIDTH-1:0] buf_wdata,
    output logic                  buf_load,
    output logic                  buf_clear,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int DEFER_W = $clog2(MAX_DEFER + 1);
    localparam logic [DEFER_W-1:0] C_DEFER_MAX = DEFER_W'(MAX_DEFER);

    ewb_state_t         state_q, state_d;
    logic [DEFER_W-1:0] defer_cnt_q, defer_cnt_d;

    logic w_hit;
    logic w_force_drain;
    logic w_idle_port;

    assign w_hit = buf_valid &&
                   (buf_address[ADDR_WIDTH-1:OFFSET_BITS] ==
                    cache_address[ADDR_WIDTH-1:OFFSET_BITS]);
    assign w_force_drain = buf_valid && (defer_cnt_q == C_DEFER_MAX);
    assign w_idle_port   = !cache_read && !cache_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            defer_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            defer_cnt_q <= defer_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        defer_cnt_d  = defer_cnt_q;
        cache_rdata  = '0;
        cache_resp   = 1'b0;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        case (state_q)
            IDLE: begin
                if (cache_read && w_hit) begin
                    cache_rdata = buf_wdata;
                    cache_resp  = 1'b1;
                end else if (cache_write && !buf_valid) begin
                    buf_load   = 1'b1;
                    cache_resp = 1'b1;
                end

                // A stalled write must be able to trigger the drain it waits on.
                if (w_force_drain) begin
                    state_d = DRAIN;
                end else if (cache_write && buf_valid) begin
                    state_d = DRAIN;
                end else if (cache_read && !w_hit) begin
                    state_d = READ;
                end else if (buf_valid && w_idle_port) begin
                    state_d = DRAIN;
                end
            end

            READ: begin
                pmem_read    = 1'b1;
                pmem_address = cache_address;
                cache_rdata  = pmem_rdata;
                cache_resp   = pmem_resp;
                if (pmem_resp) begin
                    state_d = IDLE;
                    if (buf_valid && (defer_cnt_q != C_DEFER_MAX)) begin
                        defer_cnt_d = defer_cnt_q + 1'b1;
                    end
                end
            end

            DRAIN: begin
                pmem_write   = 1'b1;
                pmem_address = buf_address;
                pmem_wdata   = buf_wdata;
                buf_clear    = pmem_resp;
                // Entry remains valid until the clear edge, so hits still forward.
                if (cache_read && w_hit) begin
                    cache_rdata = buf_wdata;
                    cache_resp  = 1'b1;
                end else if (cache_write && !buf_valid && !pmem_resp) begin
                    buf_load   = 1'b1;
                    cache_resp = 1'b1;
                end
                if (pmem_resp) begin
                    defer_cnt_d = '0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            cache_resp = 1'b0;
            buf_load   = 1'b0;
            buf_clear  = 1'b0;
            pmem_read  = 1'b0;
            pmem_write = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eviction_write_buffer_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_eviction_write_buffer_control
// Description : Directed self-checking bench for eviction_write_buffer_control.
// Revision    : 1.0
// ============================================================================
module tb_eviction_write_buffer_control;

    logic         clk;
    logic         rst;
    logic         cache_read;
    logic         cache_write;
    logic [31:0]  cache_address;
    logic [255:0] cache_rdata;
    logic         cache_resp;
    logic         buf_valid;
    logic [31:0]  buf_address;
    logic [255:0] buf_wdata;
    logic         buf_load;
    logic         buf_clear;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    logic [255:0] tb_wdata;
    int           n_tests;
    int           n_fail;

    localparam logic [255:0] LA = {8{32'hA0A0_1040}};
    localparam logic [255:0] LB = {8{32'hB0B0_2000}};
    localparam logic [255:0] LC = {8{32'hC0C0_3000}};

    eviction_write_buffer_control #(
        .MAX_DEFER  (4),
        .OFFSET_BITS(5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cache_read   (cache_read),
        .cache_write  (cache_write),
        .cache_address(cache_address),
        .cache_rdata  (cache_rdata),
        .cache_resp   (cache_resp),
        .buf_valid    (buf_valid),
        .buf_address  (buf_address),
        .buf_wdata    (buf_wdata),
        .buf_load     (buf_load),
        .buf_clear    (buf_clear),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    // Unreset single-entry datapath, as in the real buffer.
    always @(posedge clk) begin
        if (buf_clear) begin
            buf_valid <= 1'b0;
        end else if (buf_load) begin
            buf_valid   <= 1'b1;
            buf_address <= cache_address;
            buf_wdata   <= tb_wdata;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk           = 1'b0;
        rst           = 1'b1;
        cache_read    = 1'b0;
        cache_write   = 1'b1;
        cache_address = 32'h0000_1040;
        tb_wdata      = LA;
        buf_valid     = 1'b0;
        buf_address   = '0;
        buf_wdata     = '0;
        pmem_rdata    = '0;
        pmem_resp     = 1'b0;
        n_tests       = 0;
        n_fail        = 0;

        #2;
        chk("rst_buf_load", buf_load, 0);
        chk("rst_cache_resp", cache_resp, 0);
        chk("rst_pmem_write", pmem_write, 0);
        cache_write = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Absorb a writeback into the empty buffer
        cache_write = 1'b1; cache_address = 32'h0000_1040; tb_wdata = LA;
        #1;
        chk("wr_load", buf_load, 1);
        chk("wr_resp", cache_resp, 1);
        tick();
        cache_write = 1'b0;
        cache_read = 1'b1; cache_address = 32'h0000_105C;
        #1;
        chk("hit_rdata", cache_rdata, LA);
        chk("hit_resp", cache_resp, 1);
        chk("hit_no_pmem_read", pmem_read, 0);
        chk("wr_load_single", buf_load, 0);
        tick();

        // Read miss goes ahead of the buffered line
        cache_address = 32'h0000_2000;
        #1;
        chk("miss_idle_resp", cache_resp, 0);
        chk("miss_idle_pread", pmem_read, 0);
        tick();
        chk("miss_pread", pmem_read, 1);
        chk("miss_paddr", pmem_address, 32'h0000_2000);
        chk("miss_resp_early", cache_resp, 0);
        pmem_rdata = LB; pmem_resp = 1'b1;
        #1;
        chk("miss_resp", cache_resp, 1);
        chk("miss_rdata", cache_rdata, LB);
        tick();
        cache_read = 1'b0; pmem_resp = 1'b0;
        #1;
        chk("idle_pread", pmem_read, 0);
        chk("idle_pwrite", pmem_write, 0);
        tick();
        chk("drain_pwrite", pmem_write, 1);
        chk("drain_paddr", pmem_address, 32'h0000_1040);
        chk("drain_wdata", pmem_wdata, LA);
        chk("drain_clear_early", buf_clear, 0);
        pmem_resp = 1'b1;
        #1;
        chk("drain_clear", buf_clear, 1);
        tick();
        pmem_resp = 1'b0;
        #1;
        chk("clear_once", buf_clear, 0);
        chk("idle_pwrite_off", pmem_write, 0);
        chk("idle_paddr_zero", pmem_address, 0);
        chk("idle_wdata_zero", pmem_wdata, 0);

        // Four deferrals then a forced drain
        cache_write = 1'b1; cache_address = 32'h0000_1040; tb_wdata = LA;
        #1;
        chk("d_wr_load", buf_load, 1);
        tick();
        cache_write = 1'b0;
        cache_read = 1'b1; cache_address = 32'h0000_4000;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("d_idle_pwrite", pmem_write, 0);
            chk("d_idle_pread", pmem_read, 0);
            tick();
            chk("d_pread", pmem_read, 1);
            pmem_rdata = LB; pmem_resp = 1'b1;
            #1;
            chk("d_resp", cache_resp, 1);
            tick();
            pmem_resp = 1'b0;
            cache_address = 32'h0000_4000 + 32'((i + 1) * 32'h100);
        end
        #1;
        chk("f_idle_pread", pmem_read, 0);
        tick();
        chk("f_pwrite", pmem_write, 1);
        chk("f_pread", pmem_read, 0);
        chk("f_resp", cache_resp, 0);
        pmem_resp = 1'b1;
        #1;
        chk("f_clear", buf_clear, 1);
        tick();
        pmem_resp = 1'b0;
        #1;
        chk("f_idle_after", pmem_read, 0);
        tick();
        chk("f5_pread", pmem_read, 1);
        chk("f5_paddr", pmem_address, 32'h0000_4400);
        pmem_resp = 1'b1;
        #1;
        chk("f5_resp", cache_resp, 1);
        tick();
        cache_read = 1'b0; pmem_resp = 1'b0;

        // Second write stalls behind the buffered line
        cache_write = 1'b1; cache_address = 32'h0000_1040; tb_wdata = LA;
        #1;
        chk("s_wr1_load", buf_load, 1);
        tick();
        cache_address = 32'h0000_3000; tb_wdata = LC;
        #1;
        chk("s_stall_load", buf_load, 0);
        chk("s_stall_resp", cache_resp, 0);
        tick();
        chk("s_pwrite", pmem_write, 1);
        chk("s_paddr", pmem_address, 32'h0000_1040);
        pmem_resp = 1'b1;
        #1;
        chk("s_clear", buf_clear, 1);
        chk("s_clear_no_load", buf_load, 0);
        chk("s_clear_no_resp", cache_resp, 0);
        tick();
        pmem_resp = 1'b0;
        #1;
        chk("s_late_load", buf_load, 1);
        chk("s_late_resp", cache_resp, 1);
        tick();
        cache_write = 1'b0;

        // Asynchronous reset in the middle of a drain
        #1;
        chk("r_idle_pwrite", pmem_write, 0);
        tick();
        chk("r_pwrite", pmem_write, 1);
        chk("r_paddr", pmem_address, 32'h0000_3000);
        rst = 1'b1;
        #1;
        chk("r_async_drop", pmem_write, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("r_idle_after", pmem_write, 0);
        tick();
        chk("r_redrain", pmem_write, 1);
        chk("r_redrain_addr", pmem_address, 32'h0000_3000);
        chk("r_redrain_wdata", pmem_wdata, LC);
        pmem_resp = 1'b1;
        #1;
        chk("r_clear", buf_clear, 1);
        tick();
        pmem_resp = 1'b0;
        #1;
        chk("r_final_valid", buf_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eviction_write_buffer_control.md
Name: eviction_write_buffer_control

Overview:
Sequencing controller for the single-entry eviction write buffer datapath. It sits between the cache's physical-memory port and physical memory.
- Dirty-line writebacks are absorbed into the buffer and acknowledged immediately.
- Read misses go to memory ahead of buffered writebacks.
- Reads that hit the buffered line are forwarded from it.
- The buffered line is drained to memory when the port is idle, or forced after a bounded number of deferrals.

Parameters:
MAX_DEFER, 4, consecutive read misses allowed to bypass a valid buffer entry before a drain is forced.
OFFSET_BITS, 5, byte-offset bits of a 256-bit line; these are ignored in address compares.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cache_read  in  1  cache line read request, held until cache_resp
cache_write  in  1  cache line writeback request, held until cache_resp
cache_address  in  32  request line address
cache_rdata  out  256  read data returned to cache
cache_resp  out  1  single-cycle completion for read or write
buf_valid  in  1  datapath valid_out
buf_address  in  32  datapath address_out
buf_wdata  in  256  datapath wdata_out
buf_load  out  1  datapath write; datapath captures cache_address/cache_wdata, wired directly
buf_clear  out  1  datapath complete_eviction
pmem_read  out  1  memory read strobe, held until pmem_resp
pmem_write  out  1  memory write strobe, held until pmem_resp
pmem_address  out  32  memory address
pmem_wdata  out  256  memory write data
pmem_rdata  in  256  memory read data
pmem_resp  in  1  memory completion

Behaviour:
- Clock/reset: single clock clk; rst is asynchronous and active-high.
- State encoding: states IDLE, READ, DRAIN; defer_cnt is $clog2(MAX_DEFER+1) bits.
- Reset: state=IDLE, defer_cnt=0.
  - All strobes (cache_resp, buf_load, buf_clear, pmem_read, pmem_write) are 0 while rst is high.
  - Data and address outputs are 0 in IDLE.
- hit = buf_valid && buf_address[31:OFFSET_BITS]==cache_address[31:OFFSET_BITS].
- force = buf_valid && defer_cnt==MAX_DEFER.
- All outputs are combinational from state and inputs. Completion is signalled in the same cycle the condition is met.
- Write, any state except READ, when buf_valid=0 and buf_clear=0:
  - buf_load=1 and cache_resp=1 for exactly one cycle.
  - No state change.
- Write, when buf_valid=1: stall, cache_resp=0. The write is accepted the first cycle buf_valid is seen low.
- A write is never loaded in the same cycle as buf_clear; it is accepted the next cycle.
- Read with hit, in IDLE or DRAIN: cache_rdata=buf_wdata and cache_resp=1 that cycle; no memory access.
  - Forwarding is allowed during DRAIN because the entry stays valid until the clear edge.
- IDLE transitions, in priority order:
  1. force -> DRAIN.
  2. cache_read && !hit -> READ.
  3. buf_valid && !cache_read && !cache_write -> DRAIN.
  4. Otherwise stay in IDLE.
- READ:
  - pmem_read=1, pmem_address=cache_address; cache_rdata=pmem_rdata, cache_resp=pmem_resp.
  - On pmem_resp: go to IDLE, and defer_cnt += 1 if buf_valid, saturating at MAX_DEFER.
- DRAIN:
  - pmem_write=1, pmem_address=buf_address, pmem_wdata=buf_wdata.
  - On pmem_resp: buf_clear=1 that cycle, defer_cnt<=0, go to IDLE.
- Memory transactions are never aborted. A read miss arriving during DRAIN waits for the drain to complete, then goes IDLE -> READ.
- A pending cache_write with buf_valid=1 makes rule 3 false. The drain then starts only via force, or on an idle cycle.
  - To avoid deadlock, in IDLE cache_write && buf_valid -> DRAIN, priority just below force.
- Reset mid-transaction: the FSM returns to IDLE and the memory strobe drops. The datapath has no reset, so a valid entry is drained after reset exits.

Decomposition:
- Package ewb_types:
  - typedef enum {IDLE, READ, DRAIN} ewb_state_t
  - LINE_WIDTH=256, ADDR_WIDTH=32
- No sub-module. FSM and defer counter live in this module.
- A separate top, eviction_write_buffer, instantiates this controller with the datapath.

Test Plan:
- Write 0x0000_1040, line A, buffer empty -> buf_load=1 and cache_resp=1 in the same single cycle. Next idle cycle: DRAIN with pmem_write, pmem_address=0x0000_1040, pmem_wdata=A. On pmem_resp, buf_clear pulses once.
- Buffered 0x1040, then read 0x105C -> hit. cache_rdata=A and cache_resp=1 in the same cycle, pmem_read never asserted.
- Buffered 0x1040, read 0x2000 -> READ first. pmem_address=0x2000, cache_resp coincides with pmem_resp, then DRAIN follows.
- Buffered entry with 4 back-to-back read misses (MAX_DEFER=4) -> the 5th miss waits. DRAIN runs first, defer_cnt returns to 0, then the 5th read issues.
- Buffered entry, second write 0x3000 -> stall. Drain completes and buf_clear fires; no buf_load that cycle. buf_load and cache_resp come one cycle later.
- rst pulsed mid-DRAIN with pmem_resp low -> pmem_write drops immediately (asynchronous). After reset, DRAIN restarts for the still-valid entry.
